// File: rtl/bless_local_nic_if.sv
// ---------------------------------------------------------------------------
// bless_local_nic_if
// Core-side handshake bundle of the BLESS local NIC.
//   inj_data  / inj_valid / inj_ready : flit injection from the core
//   ej_data   / ej_valid  / ej_ready  : ejected flits delivered to the core
// Modports:
//   master : the core (drives inj_*, ej_ready)
//   slave  : the NIC  (drives inj_ready, ej_data, ej_valid)
// ---------------------------------------------------------------------------
interface bless_local_nic_if #(
  parameter int DATA_WIDTH = 288
);
  logic [DATA_WIDTH-1:0] inj_data;
  logic                  inj_valid;
  logic                  inj_ready;
  logic [DATA_WIDTH-1:0] ej_data;
  logic                  ej_valid;
  logic                  ej_ready;

  modport master (
    output inj_data, inj_valid, ej_ready,
    input  inj_ready, ej_data, ej_valid
  );

  modport slave (
    input  inj_data, inj_valid, ej_ready,
    output inj_ready, ej_data, ej_valid
  );
endinterface

// File: rtl/bless_local_nic.sv
// ---------------------------------------------------------------------------
// bless_local_nic
// Local network interface for a BLESS bufferless deflection router.
// Core flits are queued in a small injection FIFO and handed to the router's
// local input only in cycles where at least one network input link is idle,
// which guarantees the router a free output port. Every valid flit the router
// ejects is captured in an ejection FIFO that the core drains with valid/ready.
//
// Ports:
//   clk          router clock
//   reset        asynchronous, active-low reset
//   core         core-side handshake bundle (slave modport)
//   net_vld      vld bits of the N,E,S,W router input links this cycle
//   router_in_l  registered flit driven into the router's data_in_l
//   router_out_l flit from the router's data_out_l
//   ej_overflow  sticky: an ejected flit was dropped
//   ej_drop_cnt  saturating count of dropped ejected flits
// ---------------------------------------------------------------------------
module bless_local_nic #(
  parameter int DATA_WIDTH = 288,
  parameter int INJ_DEPTH  = 4,
  parameter int EJ_DEPTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  bless_local_nic_if.slave      core,
  input  logic [3:0]            net_vld,
  output logic [DATA_WIDTH-1:0] router_in_l,
  input  logic [DATA_WIDTH-1:0] router_out_l,
  output logic                  ej_overflow,
  output logic [7:0]            ej_drop_cnt
);
  localparam int IAW     = $clog2(INJ_DEPTH);
  localparam int EAW     = $clog2(EJ_DEPTH);
  localparam int TS_LSB  = DATA_WIDTH - 8;
  localparam int VLD_BIT = 256;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // With four inputs and four outputs, one idle input means one free output.
  function automatic logic link_idle(input logic [3:0] v);
    return (v != 4'b1111);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] stamp(input logic [DATA_WIDTH-1:0] f,
                                                  input logic [7:0]            ts);
    logic [DATA_WIDTH-1:0] r;
    r = f;
    r[DATA_WIDTH-1:TS_LSB] = ts;
    r[VLD_BIT]             = 1'b1;
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // Injection path
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] inj_mem [INJ_DEPTH];
  logic [IAW:0]          inj_wr, inj_rd;
  logic                  inj_full, inj_empty, inj_push, inj_pop;
  logic [7:0]            age_cnt;

  assign inj_empty = (inj_wr == inj_rd);
  assign inj_full  = (inj_wr[IAW] != inj_rd[IAW]) &&
                     (inj_wr[IAW-1:0] == inj_rd[IAW-1:0]);
  // Ready is held low while reset is asserted; a same-cycle pop never raises it.
  assign core.inj_ready = reset && !inj_full;
  assign inj_push       = core.inj_valid && core.inj_ready;
  assign inj_pop        = !inj_empty && link_idle(net_vld);

  always_ff @(posedge clk) begin
    if (inj_push) inj_mem[inj_wr[IAW-1:0]] <= core.inj_data;
  end

  // Stage boundary: head flit is stamped with the pre-increment age and registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inj_wr      <= '0;
      inj_rd      <= '0;
      age_cnt     <= 8'd0;
      router_in_l <= '0;
    end else begin
      age_cnt <= age_cnt + 8'd1;
      if (inj_push) inj_wr <= inj_wr + (IAW+1)'(1);
      if (inj_pop) begin
        inj_rd      <= inj_rd + (IAW+1)'(1);
        router_in_l <= stamp(inj_mem[inj_rd[IAW-1:0]], age_cnt);
      end else begin
        router_in_l <= '0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Ejection path
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] ej_mem [EJ_DEPTH];
  logic [EAW:0]          ej_wr, ej_rd;
  logic                  ej_full, ej_empty, ej_in_vld, ej_pop, ej_push, ej_drop;

  assign ej_empty  = (ej_wr == ej_rd);
  assign ej_full   = (ej_wr[EAW] != ej_rd[EAW]) &&
                     (ej_wr[EAW-1:0] == ej_rd[EAW-1:0]);
  assign ej_in_vld = router_out_l[VLD_BIT];
  assign ej_pop    = !ej_empty && core.ej_ready;
  // A full FIFO still accepts when the head leaves in the same cycle: the
  // write lands in the slot being vacated.
  assign ej_push   = ej_in_vld && (!ej_full || ej_pop);
  assign ej_drop   = ej_in_vld && ej_full && !ej_pop;

  assign core.ej_valid = !ej_empty;
  assign core.ej_data  = ej_mem[ej_rd[EAW-1:0]];

  // Stage boundary: ejected flits captured; storage cleared on reset so the
  // show-ahead head reads zero after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < EJ_DEPTH; i++) ej_mem[i] <= '0;
      ej_wr       <= '0;
      ej_rd       <= '0;
      ej_overflow <= 1'b0;
      ej_drop_cnt <= 8'd0;
    end else begin
      if (ej_push) begin
        ej_mem[ej_wr[EAW-1:0]] <= router_out_l;
        ej_wr                  <= ej_wr + (EAW+1)'(1);
      end
      if (ej_pop) ej_rd <= ej_rd + (EAW+1)'(1);
      if (ej_drop) begin
        ej_overflow <= 1'b1;
        ej_drop_cnt <= sat_inc8(ej_drop_cnt);
      end
    end
  end
endmodule
